// File: rtl/fm_param_meas.sv
// FM modulating-signal meter: counts hysteretic rising zero crossings and tracks the
// min/max of the demodulated baseband over a fixed gate of accepted samples.
//
// state      | meaning
// ST_IDLE    | after reset, waiting for the first accepted sample
// ST_MEASURE | gate in progress, accumulating crossings and min/max
// ST_UPDATE  | one cycle: publish results, start the next gate
module fm_param_meas #(
   parameter int GATE_SAMPLES = 3_200_000,
   parameter int FREQ_SCALE   = 10,
   parameter int HYST         = 16
) (
   input  logic        clk_32m,
   input  logic        rst,
   input  logic        en,
   input  logic [9:0]  demod_in,
   output logic [12:0] mod_freq,
   output logic [10:0] vpp,
   output logic        meas_valid,
   output logic        sig_lost
);

   localparam int                CW       = (GATE_SAMPLES > 1) ? $clog2(GATE_SAMPLES) : 1;
   localparam logic [CW-1:0]     LAST     = CW'(GATE_SAMPLES - 1);
   localparam logic signed [10:0] HYST_POS = 11'(HYST);
   localparam logic signed [10:0] HYST_NEG = 11'(-HYST);
   localparam logic [12:0]       CNT_MAX  = 13'h1FFF;

   typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_UPDATE} state_t;

   state_t             state_q, state_d;
   logic               in_vld_q, in_vld_d;
   logic signed [9:0]  in_s_q, in_s_d;
   logic [CW-1:0]      gate_cnt_q, gate_cnt_d;
   logic signed [9:0]  smax_q, smax_d, smin_q, smin_d;
   logic [12:0]        xcnt_q, xcnt_d;
   logic               det_hi_q, det_hi_d;
   logic [12:0]        mod_freq_q, mod_freq_d;
   logic [10:0]        vpp_q, vpp_d;
   logic               meas_valid_q, meas_valid_d;
   logic               sig_lost_q, sig_lost_d;

   logic signed [10:0] s_ext;
   logic [31:0]        prod;
   logic [CW-1:0]      cnt_base;
   logic [12:0]        xcnt_base;

   assign s_ext = {in_s_q[9], in_s_q};
   assign prod  = 32'(xcnt_q) * 32'(FREQ_SCALE);

   always_comb begin
      // Offset binary to two's complement is just an MSB flip.
      in_vld_d     = en;
      in_s_d       = {~demod_in[9], demod_in[8:0]};
      state_d      = state_q;
      gate_cnt_d   = gate_cnt_q;
      smax_d       = smax_q;
      smin_d       = smin_q;
      xcnt_d       = xcnt_q;
      det_hi_d     = det_hi_q;
      mod_freq_d   = mod_freq_q;
      vpp_d        = vpp_q;
      sig_lost_d   = sig_lost_q;
      meas_valid_d = 1'b0;
      cnt_base     = gate_cnt_q;
      xcnt_base    = xcnt_q;

      if (state_q == ST_UPDATE) begin
         mod_freq_d   = (prod > 32'(CNT_MAX)) ? CNT_MAX : prod[12:0];
         vpp_d        = {smax_q[9], smax_q} - {smin_q[9], smin_q};
         sig_lost_d   = (xcnt_q < 13'd2);
         meas_valid_d = 1'b1;
         state_d      = ST_MEASURE;
         gate_cnt_d   = '0;
         xcnt_d       = '0;
         cnt_base     = '0;
         xcnt_base    = '0;
      end

      // A sample staged during UPDATE becomes sample 0 of the next gate here.
      if (in_vld_q) begin
         if (cnt_base == '0) begin
            smax_d = in_s_q;
            smin_d = in_s_q;
         end else begin
            if (in_s_q > smax_q) smax_d = in_s_q;
            if (in_s_q < smin_q) smin_d = in_s_q;
         end
         xcnt_d = xcnt_base;
         if (!det_hi_q && (s_ext > HYST_POS)) begin
            det_hi_d = 1'b1;
            if (xcnt_base != CNT_MAX) xcnt_d = xcnt_base + 13'd1;
         end else if (det_hi_q && (s_ext < HYST_NEG)) begin
            det_hi_d = 1'b0;
         end
         if (cnt_base == LAST) begin
            state_d    = ST_UPDATE;
            gate_cnt_d = '0;
         end else begin
            state_d    = ST_MEASURE;
            gate_cnt_d = cnt_base + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_32m) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         in_vld_q     <= 1'b0;
         in_s_q       <= '0;
         gate_cnt_q   <= '0;
         smax_q       <= '0;
         smin_q       <= '0;
         xcnt_q       <= '0;
         det_hi_q     <= 1'b0;
         mod_freq_q   <= '0;
         vpp_q        <= '0;
         meas_valid_q <= 1'b0;
         sig_lost_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         in_vld_q     <= in_vld_d;
         in_s_q       <= in_s_d;
         gate_cnt_q   <= gate_cnt_d;
         smax_q       <= smax_d;
         smin_q       <= smin_d;
         xcnt_q       <= xcnt_d;
         det_hi_q     <= det_hi_d;
         mod_freq_q   <= mod_freq_d;
         vpp_q        <= vpp_d;
         meas_valid_q <= meas_valid_d;
         sig_lost_q   <= sig_lost_d;
      end
   end

   assign mod_freq   = mod_freq_q;
   assign vpp        = vpp_q;
   assign meas_valid = meas_valid_q;
   assign sig_lost   = sig_lost_q;

endmodule

// File: tb/tb_fm_param_meas.sv
// Bench for fm_param_meas: two instances (frequency scale 1 and 20) share one stimulus
// stream and are compared every cycle against a gate-level behavioural model.
module tb_fm_param_meas;

   localparam int G  = 1000;
   localparam int HY = 16;
   localparam int SC_A = 1;
   localparam int SC_B = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [9:0]  demod_in = 10'd512;

   logic [12:0] mf_a, mf_b;
   logic [10:0] vpp_a, vpp_b;
   logic        valid_a, valid_b, lost_a, lost_b;

   always #5 clk = ~clk;

   fm_param_meas #(.GATE_SAMPLES(G), .FREQ_SCALE(SC_A), .HYST(HY)) dut_a (
      .clk_32m(clk), .rst(rst), .en(en), .demod_in(demod_in),
      .mod_freq(mf_a), .vpp(vpp_a), .meas_valid(valid_a), .sig_lost(lost_a));

   fm_param_meas #(.GATE_SAMPLES(G), .FREQ_SCALE(SC_B), .HYST(HY)) dut_b (
      .clk_32m(clk), .rst(rst), .en(en), .demod_in(demod_in),
      .mod_freq(mf_b), .vpp(vpp_b), .meas_valid(valid_b), .sig_lost(lost_b));

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_on = 1'b0;
   int pulses_a = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Behavioural model: gate-level bookkeeping, results due two edges after the last sample.
   int exp_mf_a = 0, exp_mf_b = 0, exp_vpp = 0, exp_lost = 1, exp_valid = 0;
   int p_mf_a, p_mf_b, p_vpp, p_lost;
   int gate_q[$];
   bit det_hi = 1'b0;
   int pend = 0;

   function automatic int sat(input int v);
      return (v > 8191) ? 8191 : v;
   endfunction

   task automatic finish_gate();
      int mn, mx, x;
      mn = gate_q[0];
      mx = gate_q[0];
      x  = 0;
      foreach (gate_q[i]) begin
         if (gate_q[i] < mn) mn = gate_q[i];
         if (gate_q[i] > mx) mx = gate_q[i];
         if (!det_hi && gate_q[i] > HY) begin
            det_hi = 1'b1;
            x = sat(x + 1);
         end else if (det_hi && gate_q[i] < -HY) begin
            det_hi = 1'b0;
         end
      end
      p_mf_a = sat(x * SC_A);
      p_mf_b = sat(x * SC_B);
      p_vpp  = mx - mn;
      p_lost = (x < 2) ? 1 : 0;
      pend   = 2;
      gate_q.delete();
   endtask

   initial forever begin
      @(posedge clk);
      if (rst) begin
         exp_mf_a = 0; exp_mf_b = 0; exp_vpp = 0; exp_lost = 1; exp_valid = 0;
         gate_q.delete();
         det_hi = 1'b0;
         pend = 0;
      end else begin
         exp_valid = 0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               exp_mf_a = p_mf_a; exp_mf_b = p_mf_b; exp_vpp = p_vpp; exp_lost = p_lost;
               exp_valid = 1;
            end
         end
         if (en) begin
            gate_q.push_back(int'(demod_in) - 512);
            if (gate_q.size() == G) finish_gate();
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("valid_a", int'(valid_a), exp_valid);
         check("valid_b", int'(valid_b), exp_valid);
         check("mod_freq_a", int'(mf_a), exp_mf_a);
         check("mod_freq_b", int'(mf_b), exp_mf_b);
         check("vpp_a", int'(vpp_a), exp_vpp);
         check("vpp_b", int'(vpp_b), exp_vpp);
         check("sig_lost_a", int'(lost_a), exp_lost);
         check("sig_lost_b", int'(lost_b), exp_lost);
         if (valid_a) pulses_a++;
      end
   end

   // Stimulus
   int idx = 0;
   bit tog = 1'b0;

   function automatic logic [9:0] wave(input int mode, input int i);
      case (mode)
         0:       return (((i / 50) % 2) == 0) ? 10'd712 : 10'd312;
         1:       return 10'd512;
         2:       return (i % 2 == 0) ? 10'd520 : 10'd504;
         3:       return (i % 2 == 0) ? 10'd1023 : 10'd0;
         default: return 10'($urandom_range(0, 1023));
      endcase
   endfunction

   task automatic run(input int n, input int mode, input int enm);
      bit e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 1'b0;
         tog = ~tog;
         case (enm)
            0:       e = 1'b1;
            1:       e = tog;
            default: e = ($urandom_range(0, 3) != 0);
         endcase
         if (mode == 4 && $urandom_range(0, 1999) == 0) begin
            rst = 1'b1;
            e = 1'b0;
         end
         en = e;
         if (e) begin
            demod_in = wave(mode, idx);
            idx++;
         end else begin
            demod_in = 10'($urandom_range(0, 1023));
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 1'b0;
         en = 1'b0;
         demod_in = 10'($urandom_range(0, 1023));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      en = 1'b0;
      idx = 0;
   endtask

   initial begin
      int p0;
      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      check("rst_mod_freq", int'(mf_a), 0);
      check("rst_vpp", int'(vpp_a), 0);
      check("rst_valid", int'(valid_a), 0);
      check("rst_sig_lost", int'(lost_a), 1);

      // square wave 712/312, continuous strobe
      do_reset();
      p0 = pulses_a;
      run(2005, 0, 0);
      idle(3);
      check("sq_pulses", pulses_a - p0, 2);
      check("sq_mod_freq_a", int'(mf_a), 10);
      check("sq_mod_freq_b", int'(mf_b), 200);
      check("sq_vpp", int'(vpp_a), 400);
      check("sq_sig_lost", int'(lost_a), 0);

      // constant mid-scale
      do_reset();
      run(2005, 1, 0);
      idle(3);
      check("dc_mod_freq", int'(mf_a), 0);
      check("dc_vpp", int'(vpp_a), 0);
      check("dc_sig_lost", int'(lost_a), 1);

      // +-8 inside hysteresis
      do_reset();
      run(2005, 2, 0);
      idle(3);
      check("hyst_mod_freq", int'(mf_a), 0);
      check("hyst_vpp", int'(vpp_a), 16);
      check("hyst_sig_lost", int'(lost_a), 1);

      // square wave with strobe every other cycle
      do_reset();
      p0 = pulses_a;
      run(4010, 0, 1);
      idle(3);
      check("half_pulses", pulses_a - p0, 2);
      check("half_mod_freq", int'(mf_a), 10);
      check("half_vpp", int'(vpp_a), 400);

      // full-scale alternation: 500 crossings, scale 20 saturates
      do_reset();
      run(1005, 3, 0);
      idle(3);
      check("fs_mod_freq_a", int'(mf_a), 500);
      check("fs_mod_freq_b", int'(mf_b), 8191);
      check("fs_vpp", int'(vpp_a), 1023);
      check("fs_sig_lost", int'(lost_a), 0);

      // reset in the middle of the second gate
      do_reset();
      run(1500, 0, 0);
      do_reset();
      idle(1);
      check("midrst_mod_freq", int'(mf_a), 0);
      check("midrst_vpp", int'(vpp_a), 0);
      check("midrst_sig_lost", int'(lost_a), 1);
      p0 = pulses_a;
      run(1005, 0, 0);
      idle(3);
      check("midrst_pulses", pulses_a - p0, 1);
      check("post_mod_freq", int'(mf_a), 10);
      check("post_vpp", int'(vpp_a), 400);
      check("post_sig_lost", int'(lost_a), 0);

      // random data, random strobe, rare resets
      do_reset();
      run(3000, 4, 2);
      idle(3);

      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
